oam_dma_arbiter: RTL
====================

# oam_dma_arbiter

Bus controller between the CPU and the 64K system RAM. It passes CPU accesses straight through to the RAM. A CPU write to the OAM DMA register halts the CPU, takes the RAM bus, and copies one 256-byte page into the PPU OAM data port. It then returns the bus to the CPU.

## Interface
Parameters:
- DMA_REG_ADDR, 16'h4014, CPU write address that triggers a DMA.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cpu_addr  in  16  CPU address.
- cpu_wdata  in  8  CPU write data.
- cpu_rw_n  in  1  1 = read, 0 = write.
- cpu_cs_n  in  1  0 = CPU access this cycle.
- cpu_rdata  out  8  read data to the CPU; equals mem_rdata.
- cpu_rdy  out  1  1 = CPU may proceed; 0 = CPU halted and must hold its request.
- mem_addr  out  16  RAM address.
- mem_wdata  out  8  RAM write data. The top level drives the RAM inout bus from this whenever mem_rw_n = 0.
- mem_rw_n  out  1  RAM read/write select.
- mem_cs_n  out  1  RAM chip select, active-low.
- mem_rdata  in  8  RAM read data bus.
- oam_wdata  out  8  byte to the PPU OAM data port.
- oam_we  out  1  single-cycle OAM write strobe.
- dma_busy  out  1  1 while the DMA owns the bus.

## Operation
- RAM model: a read with mem_cs_n = 0 and mem_rw_n = 1 in cycle N is captured at the end-of-N edge. Its data is valid on mem_rdata throughout cycle N+1. Writes commit at the end-of-N edge.
- cyc_odd: free-running 1-bit toggle. It is 0 in the first cycle after reset release and toggles on every edge.
- FSM states:
  - IDLE: cpu_rdy = 1. mem_addr, mem_wdata, mem_rw_n and mem_cs_n pass through combinationally from the cpu_* inputs.
    - Exception: if cpu_cs_n = 0, cpu_rw_n = 0 and cpu_addr = DMA_REG_ADDR, then mem_cs_n is forced to 1. page <= cpu_wdata, and the next state is HALT.
  - HALT: one cycle, mem_cs_n = 1. The next state is READ if cyc_odd = 1 in this cycle, else ALIGN.
  - ALIGN: one cycle, mem_cs_n = 1. The next state is READ.
  - READ: mem_addr = {page, idx}, mem_rw_n = 1, mem_cs_n = 0. The next state is WRITE.
  - WRITE: mem_cs_n = 1. mem_rdata is valid in this cycle.
    - At the end-of-cycle edge: oam_wdata <= mem_rdata, oam_we <= 1 (for exactly the next cycle), idx <= idx + 1 (8-bit, wraps).
    - The next state is READ if idx != 8'hFF before the increment, else IDLE.
- cpu_rdy = 0 in HALT, ALIGN, READ and WRITE. dma_busy = !cpu_rdy.
- CPU requests while cpu_rdy = 0 are never forwarded to RAM. The CPU holds its request, and it is forwarded in the first IDLE cycle.
- Exactly 256 oam_we pulses occur per DMA, for addresses {page,8'h00} through {page,8'hFF} in ascending order. The final pulse occurs in the first IDLE cycle.
- idx is cleared to 0 on entry to HALT.

## Timing
- Reset values: state IDLE, cpu_rdy = 1, dma_busy = 0, oam_we = 0, oam_wdata = 8'h00, page = 8'h00, idx = 8'h00, cyc_odd = 0. While rst_n = 0, mem_cs_n is forced to 1.
- Reset mid-DMA takes effect immediately, independent of clk. The partial transfer is abandoned, and no further oam_we pulses occur.
- Cycle numbering: the trigger write occurs in cycle T with cyc_odd = p.
  - HALT is cycle T+1.
  - If p = 0, the first READ is cycle T+2 and cpu_rdy is low for 513 cycles.
  - If p = 1, the first READ is cycle T+3 and cpu_rdy is low for 514 cycles.
- Every READ cycle has cyc_odd = 0.
- Byte k (0..255) is read in cycle R0+2k, where R0 is the first READ cycle. Its oam_we pulse is in cycle R0+2k+2.
- Pass-through read latency is 1 cycle: the address is in cycle N and cpu_rdata is valid in N+1.

## Test plan
- Pass-through: preload RAM[0x0605] = 0x40, CPU reads 0x0605 -> cpu_rdata = 0x40 in the next cycle. CPU writes 0x55 to 0x0300, then reads it back -> 0x55. cpu_rdy stays 1 throughout.
- Full DMA: preload RAM[0x0200+i] = i ^ 0xA5, CPU writes 0x02 to 0x4014 -> 256 oam_we pulses with oam_wdata = i ^ 0xA5 in order, mem_addr sweeps 0x0200..0x02FF, and dma_busy mirrors !cpu_rdy.
- Alignment: trigger once with cyc_odd = 0 and once with cyc_odd = 1 -> cpu_rdy low for 513 and 514 cycles respectively, and every READ has cyc_odd = 0.
- Halted CPU: the CPU holds a write of 0x77 to 0x0010 from the cycle after the trigger -> RAM[0x0010] is unchanged until the first IDLE cycle, then written once to 0x77.
- Register intercept: the trigger write of 0x03 to 0x4014 -> mem_cs_n = 1 in cycle T, and RAM[0x4014] keeps its preload value.
- Reset mid-DMA: assert rst_n = 0 after the 100th oam_we pulse -> outputs go to their reset values without waiting for a clock edge. A new trigger after release produces a complete 256-byte transfer.

Source files
------------

// File: rtl/oam_dma_arbiter.sv
// oam_dma_arbiter: CPU/RAM bus controller with a 256-byte OAM DMA engine.
// A CPU write to DMA_REG_ADDR halts the CPU and copies RAM page {page,00..FF}
// into the PPU OAM data port, then hands the bus back to the CPU.
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   cpu_addr/wdata  CPU address / write data
//   cpu_rw_n        1 = read, 0 = write
//   cpu_cs_n        0 = CPU access this cycle
//   cpu_rdata       read data to CPU (mem_rdata)
//   cpu_rdy         1 = CPU may proceed, 0 = CPU halted
//   mem_addr/wdata  RAM address / write data
//   mem_rw_n        RAM read/write select
//   mem_cs_n        RAM chip select, active-low
//   mem_rdata       RAM read data
//   oam_wdata       byte to OAM data port
//   oam_we          single-cycle OAM write strobe
//   dma_busy        1 while the DMA owns the bus

module oam_dma_arbiter #(
    parameter logic [15:0] DMA_REG_ADDR = 16'h4014
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_rw_n,
    input  logic        cpu_cs_n,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_rdy,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_rw_n,
    output logic        mem_cs_n,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  oam_wdata,
    output logic        oam_we,
    output logic        dma_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_READ,
        S_WRITE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_page;
    logic [7:0]  r_idx;
    logic [7:0]  r_oam_wdata;
    logic        r_oam_we;
    logic        r_cyc_odd;
    logic        w_trig;
    logic        w_last;

    assign w_trig = !cpu_cs_n && !cpu_rw_n && (cpu_addr == DMA_REG_ADDR);
    assign w_last = (r_idx == 8'hFF);

    always_comb begin
        w_next    = r_state;
        cpu_rdy   = 1'b0;
        mem_addr  = {r_page, r_idx};
        mem_wdata = cpu_wdata;
        mem_rw_n  = 1'b1;
        mem_cs_n  = 1'b1;
        case (r_state)
            S_IDLE: begin
                cpu_rdy  = 1'b1;
                mem_addr = cpu_addr;
                mem_rw_n = cpu_rw_n;
                mem_cs_n = cpu_cs_n;
                // The DMA register is not backed by RAM.
                if (w_trig) begin
                    mem_cs_n = 1'b1;
                    w_next   = S_HALT;
                end
            end
            // Reads must land on even cycles; burn one more if needed.
            S_HALT:  w_next = r_cyc_odd ? S_READ : S_ALIGN;
            S_ALIGN: w_next = S_READ;
            S_READ: begin
                mem_cs_n = 1'b0;
                w_next   = S_WRITE;
            end
            S_WRITE: w_next = w_last ? S_IDLE : S_READ;
            default: w_next = S_IDLE;
        endcase
        if (!rst_n) begin
            mem_cs_n = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_page      <= 8'h00;
            r_idx       <= 8'h00;
            r_oam_wdata <= 8'h00;
            r_oam_we    <= 1'b0;
            r_cyc_odd   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cyc_odd <= !r_cyc_odd;
            r_oam_we  <= 1'b0;
            if (r_state == S_IDLE && w_trig) begin
                r_page <= cpu_wdata;
                r_idx  <= 8'h00;
            end
            // RAM data from the previous READ is valid now.
            if (r_state == S_WRITE) begin
                r_oam_wdata <= mem_rdata;
                r_oam_we    <= 1'b1;
                r_idx       <= r_idx + 8'd1;
            end
        end
    end

    assign cpu_rdata = mem_rdata;
    assign oam_wdata = r_oam_wdata;
    assign oam_we    = r_oam_we;
    assign dma_busy  = !cpu_rdy;

endmodule
